// File: rtl/dram_responder.sv
// dram_responder: single-outstanding memory request responder with
// programmable wait states in front of a synchronous RAM backend.
//
// State table:
//   IDLE   | waiting for a read/write strobe; only state that accepts requests
//   WAIT   | burning WAIT_STATES idle cycles before touching the RAM
//   ACCESS | one-cycle RAM strobe (ram_en=1, ram_we=lanes for writes)
//   RDATA  | reads only: capture ram_rdata into dram_mem_read_data
//   DONE   | one-cycle dram_ack, then back to IDLE
//
// Ports:
//   clk, reset_n (async, active low), sync_reset (sync, active high)
//   dram_mem_*   : requester side (addr, read/write strobes, lanes, data)
//   dram_ack     : one-cycle completion pulse
//   ram_*        : backend RAM interface (read data valid one cycle after access)
//   err_clr      : clears sticky overrun_err / proto_err
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 16
`endif
`ifndef XLEN
`define XLEN 32
`endif

module dram_responder #(
  parameter int ADDR_BITS   = `MEM_ADDR_BITS,
  parameter int DATA_BITS   = `XLEN,
  parameter int WAIT_STATES = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sync_reset,
  input  logic [ADDR_BITS-1:0]   dram_mem_addr,
  input  logic                   dram_mem_read_en,
  input  logic                   dram_mem_write_en,
  input  logic [DATA_BITS/8-1:0] dram_mem_byte_enable,
  input  logic [DATA_BITS-1:0]   dram_mem_write_data,
  output logic                   dram_ack,
  output logic [DATA_BITS-1:0]   dram_mem_read_data,
  output logic                   ram_en,
  output logic [DATA_BITS/8-1:0] ram_we,
  output logic [ADDR_BITS-1:0]   ram_addr,
  output logic [DATA_BITS-1:0]   ram_wdata,
  input  logic [DATA_BITS-1:0]   ram_rdata,
  input  logic                   err_clr,
  output logic                   overrun_err,
  output logic                   proto_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_ACCESS = 3'd2;
  localparam logic [2:0] S_RDATA  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  logic [2:0]             state;
  logic [3:0]             wait_cnt;
  logic                   is_write;
  logic [DATA_BITS/8-1:0] be_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [DATA_BITS-1:0]   wdata_q;
  logic [DATA_BITS-1:0]   rdata_q;
  logic                   ovr_q;
  logic                   proto_q;

  logic strobe;
  logic both_strobes;
  assign strobe       = dram_mem_read_en | dram_mem_write_en;
  assign both_strobes = dram_mem_read_en & dram_mem_write_en;

  // Backend strobes are decoded from state so they can never leak outside ACCESS.
  assign ram_en             = (state == S_ACCESS);
  assign ram_we             = (state == S_ACCESS && is_write) ? be_q : '0;
  assign ram_addr           = addr_q;
  assign ram_wdata          = wdata_q;
  assign dram_ack           = (state == S_DONE);
  assign dram_mem_read_data = rdata_q;
  assign overrun_err        = ovr_q;
  assign proto_err          = proto_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      is_write <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ovr_q    <= 1'b0;
      proto_q  <= 1'b0;
    end else if (sync_reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      is_write <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ovr_q    <= 1'b0;
      proto_q  <= 1'b0;
    end else begin
      // Sticky flags: a set event in the same cycle beats err_clr.
      if (strobe && state != S_IDLE) ovr_q <= 1'b1;
      else if (err_clr)              ovr_q <= 1'b0;
      if (both_strobes)              proto_q <= 1'b1;
      else if (err_clr)              proto_q <= 1'b0;

      case (state)
        S_IDLE: begin
          if (strobe) begin
            addr_q   <= dram_mem_addr;
            be_q     <= dram_mem_byte_enable;
            wdata_q  <= dram_mem_write_data;
            is_write <= dram_mem_write_en;   // both strobes high resolves to write
            wait_cnt <= WS;
            state    <= (WS != 4'd0) ? S_WAIT : S_ACCESS;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt <= 4'd1) state <= S_ACCESS;
        end
        S_ACCESS: state <= is_write ? S_DONE : S_RDATA;
        S_RDATA: begin
          rdata_q <= ram_rdata;
          state   <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
